mux16_rr_burst_ctrl: RTL and testbench

Round-robin burst controller for a shared 16:1 single-bit multiplexer (`mux_16x1`). It arbitrates among 16 requesters and drives the mux `select_lines` to the winner. While the winner holds the channel, it samples `mux_output` for a fixed number of cycles and presents the collected word as one burst. It sits between the requester logic and the mux; the mux stays purely combinational.

---
 rtl/mux16_rr_burst_ctrl.sv | 158 +++++++++++++++
 tb/tb_mux16_rr_burst_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_burst_ctrl.sv
// Round-robin burst controller for a shared 16:1 single-bit mux: grants one
// requester at a time and collects BURST_LEN serial bits per grant.
module mux16_rr_burst_ctrl #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          req,
    input  logic                 mux_output,
    output logic [3:0]           select_lines,
    output logic [15:0]          grant,
    output logic                 busy,
    output logic                 burst_valid,
    output logic [BURST_LEN-1:0] burst_data,
    output logic [3:0]           burst_src,
    output logic                 burst_abort
);

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 abort_q, abort_d;
    logic [BURST_LEN-1:0] data_q, data_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [BURST_LEN-1:0] coll_q, coll_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic [BURST_LEN-1:0] coll_samp;
    logic                 last_bit;

    // First requesting index at or after the pointer, wrapping mod 16.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Collection word with the current mux bit dropped into slot cnt_q.
    always_comb begin
        coll_samp = coll_q;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                coll_samp[k] = mux_output;
            end
        end
    end

    assign last_bit = (cnt_q == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        abort_d = 1'b0;
        data_d  = data_q;
        src_d   = src_q;
        coll_d  = coll_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_XFER;
                    sel_d   = win_idx;
                    grant_d = N_REQ'(1) << win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    coll_d  = '0;
                end
            end
            S_XFER: begin
                if (req[sel_q]) begin
                    coll_d = coll_samp;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Only completed bursts are published to burst_data.
                        valid_d = 1'b1;
                        data_d  = coll_samp;
                        src_d   = sel_q;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        ptr_d   = sel_q + IDX_W'(1);
                        state_d = S_IDLE;
                    end
                end else begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + IDX_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            coll_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            src_q   <= src_d;
            coll_q  <= coll_d;
        end
    end

    assign select_lines = sel_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign burst_valid  = valid_q;
    assign burst_data   = data_q;
    assign burst_src    = src_q;
    assign burst_abort  = abort_q;

endmodule

// File: tb/tb_mux16_rr_burst_ctrl.sv
// Directed bench for mux16_rr_burst_ctrl (BURST_LEN = 4); inputs driven and
// outputs checked on the falling clock edge.
module tb_mux16_rr_burst_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        mux_output;
    logic [3:0]  select_lines;
    logic [15:0] grant;
    logic        busy;
    logic        burst_valid;
    logic [3:0]  burst_data;
    logic [3:0]  burst_src;
    logic        burst_abort;

    int n_vec = 0;
    int n_err = 0;

    mux16_rr_burst_ctrl #(.BURST_LEN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .mux_output   (mux_output),
        .select_lines (select_lines),
        .grant        (grant),
        .busy         (busy),
        .burst_valid  (burst_valid),
        .burst_data   (burst_data),
        .burst_src    (burst_src),
        .burst_abort  (burst_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sel"},   32'(select_lines), 32'd0);
        chk({tag, ".grant"}, 32'(grant),        32'd0);
        chk({tag, ".busy"},  32'(busy),         32'd0);
        chk({tag, ".valid"}, 32'(burst_valid),  32'd0);
        chk({tag, ".abort"}, 32'(burst_abort),  32'd0);
        chk({tag, ".data"},  32'(burst_data),   32'd0);
        chk({tag, ".src"},   32'(burst_src),    32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        req        = 16'h0000;
        mux_output = 1'b0;
        #2 rst_n   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_req.busy", 32'(busy), 32'd0);

        // Single request: requester 5, serial bits 1,0,1,1 -> 4'b1101.
        req = 16'h0020;
        tick();
        chk("single.sel",   32'(select_lines), 32'd5);
        chk("single.grant", 32'(grant),        32'h0020);
        chk("single.busy",  32'(busy),         32'd1);
        mux_output = 1'b1;
        tick();
        chk("single.grant_c2", 32'(grant), 32'h0020);
        mux_output = 1'b0;
        tick();
        mux_output = 1'b1;
        tick();
        mux_output = 1'b1;
        chk("single.grant_c4", 32'(grant),       32'h0020);
        chk("single.valid_early", 32'(burst_valid), 32'd0);
        tick();
        chk("single.valid", 32'(burst_valid), 32'd1);
        chk("single.data",  32'(burst_data),  32'hD);
        chk("single.src",   32'(burst_src),   32'd5);
        chk("single.grant_drop", 32'(grant),  32'd0);
        chk("single.busy_drop",  32'(busy),   32'd0);
        req        = 16'h0000;
        mux_output = 1'b0;
        tick();
        chk("single.valid_pulse", 32'(burst_valid), 32'd0);
        chk("single.sel_hold",    32'(select_lines), 32'd5);

        // Fairness from pointer 0 (fresh reset): src 0..15, valid every 5 cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 16'hFFFF;
        for (int b = 0; b < 16; b++) begin
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c < 5) begin
                    chk($sformatf("fair%0d.valid_low", b), 32'(burst_valid), 32'd0);
                end else begin
                    chk($sformatf("fair%0d.valid", b), 32'(burst_valid), 32'd1);
                    chk($sformatf("fair%0d.src",   b), 32'(burst_src),   32'(b));
                end
            end
        end

        // Pointer wrap: after winner 15, req 16'h4001 gives 0 then 14.
        req        = 16'h4001;
        mux_output = 1'b1;
        tick();
        chk("wrap.sel0",   32'(select_lines), 32'd0);
        chk("wrap.grant0", 32'(grant),        32'h0001);
        repeat (4) tick();
        chk("wrap.valid0", 32'(burst_valid), 32'd1);
        chk("wrap.src0",   32'(burst_src),   32'd0);
        tick();
        chk("wrap.sel14",   32'(select_lines), 32'd14);
        chk("wrap.grant14", 32'(grant),        32'h4000);
        repeat (4) tick();
        chk("wrap.valid14", 32'(burst_valid), 32'd1);
        chk("wrap.src14",   32'(burst_src),   32'd14);
        chk("wrap.data14",  32'(burst_data),  32'hF);

        // Abort: requester 3 drops after two sampled bits.
        req        = 16'h0008;
        mux_output = 1'b0;
        tick();
        chk("abort.sel", 32'(select_lines), 32'd3);
        tick();
        tick();
        req = 16'h0000;
        tick();
        chk("abort.pulse", 32'(burst_abort), 32'd1);
        chk("abort.valid", 32'(burst_valid), 32'd0);
        chk("abort.busy",  32'(busy),        32'd0);
        chk("abort.grant", 32'(grant),       32'd0);
        chk("abort.data",  32'(burst_data),  32'hF);
        chk("abort.src",   32'(burst_src),   32'd14);
        req = 16'h0018;
        tick();
        chk("abort.pulse_once", 32'(burst_abort), 32'd0);
        chk("abort.ptr4_sel",   32'(select_lines), 32'd4);
        req = 16'h0000;
        tick();
        chk("abort2.pulse", 32'(burst_abort), 32'd1);

        // Non-preemption: req[1] raised during requester 2's burst.
        req = 16'h0004;
        tick();
        chk("nopre.sel2", 32'(select_lines), 32'd2);
        req = 16'h0006;
        tick();
        chk("nopre.grant_hold", 32'(grant), 32'h0004);
        repeat (3) tick();
        chk("nopre.valid", 32'(burst_valid), 32'd1);
        chk("nopre.src",   32'(burst_src),   32'd2);
        tick();
        chk("nopre.sel1",   32'(select_lines), 32'd1);
        chk("nopre.grant1", 32'(grant),        32'h0002);

        // Reset mid-burst: outputs clear immediately, then normal latency.
        req = 16'h0000;
        tick();
        req = 16'h0010;
        tick();
        chk("rstmid.sel4", 32'(select_lines), 32'd4);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("rstmid");
        req = 16'h0100;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid.sel8",   32'(select_lines), 32'd8);
        chk("rstmid.grant8", 32'(grant),        32'h0100);
        chk("rstmid.abort",  32'(burst_abort),  32'd0);
        repeat (4) tick();
        chk("rstmid.valid8", 32'(burst_valid), 32'd1);
        chk("rstmid.src8",   32'(burst_src),   32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
